// File: rtl/ariane_pkg.sv
// Shared frontend types: the branch-history-table update record and queue defaults.
package ariane_pkg;

    localparam int unsigned BHT_UPD_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_update_t;

endpackage

// File: rtl/riscv.sv
// Core-wide RISC-V architectural constants used by the frontend interfaces.
package riscv;

    localparam int unsigned VLEN = 64;

endpackage

// File: rtl/bht_update_queue.sv
// Buffers resolved conditional-branch outcomes and hands them to the BHT one per
// accepted cycle, merging repeated outcomes for the same PC into the youngest entry.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH    = BHT_UPD_QUEUE_DEPTH,
    parameter bit          COALESCE = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic                   resolved_valid_i,
    input  logic [riscv::VLEN-1:0] resolved_pc_i,
    input  logic                   resolved_taken_i,
    input  logic                   resolved_is_cond_i,
    input  logic                   bht_ready_i,
    output bht_update_t            bht_update_o,
    output logic                   full_o,
    output logic [7:0]             drop_cnt_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [riscv::VLEN-1:0] pc_q [DEPTH];
    logic [riscv::VLEN-1:0] pc_d [DEPTH];
    logic [DEPTH-1:0]       taken_q, taken_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic          accept;
    logic          out_valid;
    logic          pop;
    logic          coalesce;
    logic          push;
    logic          overflow;
    logic [PW-1:0] youngest;

    // Classify this cycle's event: accept, pop, merge into the youngest entry, push, or drop.
    always_comb begin
        youngest  = tail_q - PW'(1);
        accept    = resolved_valid_i & resolved_is_cond_i & ~debug_mode_i & ~flush_i;
        out_valid = (count_q != '0) & ~flush_i & ~debug_mode_i;
        pop       = out_valid & bht_ready_i;
        coalesce  = COALESCE & accept & (count_q != '0)
                  & (pc_q[youngest] == resolved_pc_i)
                  & ~(pop & (count_q == CW'(1)));
        push      = accept & ~coalesce & ((count_q != DEPTH_C) | pop);
        overflow  = accept & ~coalesce & (count_q == DEPTH_C) & ~pop;
    end

    // Next queue state; a flush empties the queue but keeps the drop history.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_d       = pc_q;
        taken_d    = taken_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (coalesce) begin
                taken_d[youngest] = resolved_taken_i;
            end
            if (push) begin
                pc_d[tail_q]    = resolved_pc_i;
                taken_d[tail_q] = resolved_taken_i;
                tail_d          = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push & ~pop) begin
                count_d = count_q + CW'(1);
            end else if (pop & ~push) begin
                count_d = count_q - CW'(1);
            end
            if (overflow && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // Register the queue state; reset wipes storage so the idle output reads all zeros.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            taken_q    <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            taken_q    <= taken_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

    // Present the head entry; valid is masked while flushing or in debug mode.
    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = out_valid;
        bht_update_o.pc    = pc_q[head_q];
        bht_update_o.taken = taken_q[head_q];
        full_o             = (count_q == DEPTH_C);
        drop_cnt_o         = drop_cnt_q;
    end

endmodule
